uart_count_msg_fmt: RTL and testbench
=====================================

// Module: uart_count_msg_fmt
// PURPOSE
//  Upstream formatter for the 11-byte UART sender.
//  - Accepts a binary count and converts it to three ASCII decimal digits by sequential repeated subtraction.
//  - Packs the digits into the 88-bit frame "COUNT:hto\r\n", pulses the sender trigger, then waits for the sender's done pulse.
//  - A one-entry pending slot keeps the newest count that arrives while busy.
// PARAMETERS
//  VALUE_W  10   width of value input
//  SAT_VAL  999  inputs above this saturate to SAT_VAL (must be <=999)
// PORTS
//  sclk               in   1   system clock; single clock domain
//  rst                in   1   synchronous, active-high reset
//  value              in   VALUE_W  count to report
//  value_valid        in   1   one-cycle request strobe; value sampled same edge
//  send_11bytes       out  88  frame; [87:80] is first byte on the wire
//  send_11bytes_trig  out  1   one-cycle start pulse to sender
//  send_11bytes_done  in   1   one-cycle pulse from sender after byte 11
//  busy               out  1   high from accept until done consumed
//  msg_done           out  1   registered one-cycle echo of accepted done
//  pend_overwrite     out  1   one-cycle pulse when a pending value is replaced
// BEHAVIOUR
//  Reset: all outputs 0, send_11bytes=0, state IDLE, pending slot empty.
//  Saturation: on capture, v = (value>SAT_VAL) ? SAT_VAL : value.
//  States: IDLE -> CONV_H -> CONV_T -> EMIT -> WAIT -> (IDLE | CONV_H).
//  - IDLE: value_valid -> capture v into rem, clear h/t, go to CONV_H, busy=1.
//  - CONV_H: each cycle, if rem>=100 then rem-=100, h++; else go to CONV_T.
//  - CONV_T: each cycle, if rem>=10 then rem-=10, t++; else go to EMIT.
//  - EMIT: load frame {"COUNT:",h+8'h30,t+8'h30,rem+8'h30,8'h0D,8'h0A}, trig=1 for this cycle only, go to WAIT.
//  Latency: trig high exactly h+t+3 cycles after the accepting edge (0 -> 3, 999 -> 21).
//  Frame hold: send_11bytes stays stable from trig until the cycle after done; the sender reads bytes lazily.
//  WAIT: on send_11bytes_done, msg_done=1 next cycle, then:
//  - value_valid this cycle -> restart CONV_H with it; it is newer than pending, pending cleared.
//  - else pending full -> restart CONV_H with pending, pending cleared.
//  - else go to IDLE, busy=0.
//  Pending slot:
//  - value_valid in any state except IDLE stores v into pending.
//  - The WAIT+done case is excepted; it is handled by the restart rule above.
//  - If pending was already full, pend_overwrite=1 for one cycle.
//  Simultaneous events and boundaries:
//  - done outside WAIT is ignored; msg_done stays 0.
//  - trig is never re-asserted before done is received.
//  - rst mid-conversion or in WAIT returns to IDLE next edge; pending dropped, trig/msg_done never asserted.
//  - The sender still mid-frame after rst is the system's concern; rst is shared.
//  Widths: rem is 10 bits; h,t,u are 4 bits and never exceed 9.
// CONFIGURATION
//  ZERO_BLANK_EN defined:
//  - Leading-zero hundreds digit sends 8'h20 (space).
//  - Tens digit is also blanked when the hundreds digit is blanked and t==0.
//  - Units digit is always shown; 7 -> "COUNT:  7\r\n".
//  ZERO_BLANK_EN undefined: always three digits, 7 -> "COUNT:007\r\n".
//  Latency is identical in both builds.
// STRUCTURE
//  Package uart_fmt_pkg:
//  - ASCII constants: ASC_0=8'h30, ASC_SP=8'h20, ASC_CR=8'h0D, ASC_LF=8'h0A.
//  - PREFIX_COUNT = 48-bit "COUNT:".
//  - FRAME_BYTES = 11.
//  - State encoding localparams: IDLE, CONV_H, CONV_T, EMIT, WAIT.
//  Sub-module bin2dec_3dig:
//  - Ports: start, bin, busy, done, h, t, u.
//  - Holds the CONV_H/CONV_T subtract loop.
//  - Top keeps the FSM, pending slot and frame register.
// TESTING
//  T1: reset, value=0 valid -> trig at +3 cycles, frame "COUNT:000\r\n" (blank build: "COUNT:  0\r\n").
//  T2: value=999 -> trig at +21 cycles, "COUNT:999\r\n"; frame stable until done+1.
//  T3: value=1023 -> saturates -> "COUNT:999\r\n". value=105 -> "COUNT:105\r\n" (blank build: tens zero kept).
//  T4: value=12 accepted; during WAIT value=34 then 56 strobed.
//  -> pend_overwrite pulse on 56; after done, next frame "COUNT:056\r\n"; 34 never sent.
//  T5: value_valid=77 in the same cycle as done, with 40 pending -> 77 sent next, pending empty, then IDLE.
//  T6: rst asserted in CONV_T and again in WAIT.
//  -> IDLE next edge, busy=0, no trig/msg_done; a stray done afterwards is ignored.
//  Scoreboard: 11-byte sender model; check every transmitted byte against expected ASCII.

Source files
------------

// File: rtl/uart_fmt_pkg.sv
// Shared constants and types for the UART count-message formatter.
package uart_fmt_pkg;

  localparam logic [7:0]  ASC_0  = 8'h30;
  localparam logic [7:0]  ASC_SP = 8'h20;
  localparam logic [7:0]  ASC_CR = 8'h0D;
  localparam logic [7:0]  ASC_LF = 8'h0A;

  localparam logic [47:0] PREFIX_COUNT = "COUNT:";

  localparam int FRAME_BYTES = 11;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int REM_W       = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_H = 3'd1,
    CONV_T = 3'd2,
    EMIT   = 3'd3,
    WAIT   = 3'd4
  } state_t;

  function automatic logic [7:0] dig2asc(input logic [3:0] d);
    return ASC_0 + {4'b0000, d};
  endfunction

endpackage

// File: rtl/bin2dec_3dig.sv
// Binary (0..999) to three decimal digits by repeated subtraction of 100 then 10.
// done is combinational on the last tens-check cycle; digits hold until the next start.
module bin2dec_3dig
  import uart_fmt_pkg::*;
(
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic [REM_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       h,
  output logic [3:0]       t,
  output logic [3:0]       u
);

  state_t           st_q;
  logic [REM_W-1:0] rem_q;
  logic [3:0]       h_q;
  logic [3:0]       t_q;

  always_ff @(posedge sclk) begin
    if (rst) begin
      st_q  <= IDLE;
      rem_q <= '0;
      h_q   <= '0;
      t_q   <= '0;
    end else if (start) begin
      st_q  <= CONV_H;
      rem_q <= bin;
      h_q   <= '0;
      t_q   <= '0;
    end else begin
      case (st_q)
        CONV_H: begin
          if (rem_q >= 10'd100) begin
            rem_q <= rem_q - 10'd100;
            h_q   <= h_q + 4'd1;
          end else begin
            st_q <= CONV_T;
          end
        end
        CONV_T: begin
          if (rem_q >= 10'd10) begin
            rem_q <= rem_q - 10'd10;
            t_q   <= t_q + 4'd1;
          end else begin
            st_q <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // Input is saturated to 999 upstream, so the remainder is a single digit here.
  assign busy = (st_q != IDLE);
  assign done = (st_q == CONV_T) && (rem_q < 10'd10);
  assign h    = h_q;
  assign t    = t_q;
  assign u    = rem_q[3:0];

endmodule

// File: rtl/uart_count_msg_fmt.sv
// Formats a count as "COUNT:hto\r\n" for the 11-byte UART sender; trig fires h+t+3 cycles after accept.
// Define ZERO_BLANK_EN to send leading zero digits as spaces (units always shown).
module uart_count_msg_fmt
  import uart_fmt_pkg::*;
#(
  parameter int          VALUE_W = 10,
  parameter int unsigned SAT_VAL = 999
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic [FRAME_W-1:0] send_11bytes,
  output logic               send_11bytes_trig,
  input  logic               send_11bytes_done,
  output logic               busy,
  output logic               msg_done,
  output logic               pend_overwrite
);

  state_t             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic               trig_q;
  logic               busy_q;
  logic               msg_done_q;
  logic               ovw_q;
  logic               pend_vld_q;
  logic [REM_W-1:0]   pend_val_q;

  logic [REM_W-1:0]   v_sat;
  logic               wait_done;
  logic               pend_store;
  logic               cv_start;
  logic [REM_W-1:0]   cv_bin;
  logic               cv_busy;
  logic               cv_done;
  logic [3:0]         cv_h;
  logic [3:0]         cv_t;
  logic [3:0]         cv_u;
  logic [7:0]         h_chr;
  logic [7:0]         t_chr;
  logic [7:0]         u_chr;

  always_comb begin
    v_sat = REM_W'(value);
    if (32'(value) > 32'(SAT_VAL)) v_sat = REM_W'(SAT_VAL);
  end

  // A strobe landing with done is the newest value and wins over the pending slot.
  always_comb begin
    wait_done  = (state_q == WAIT) && send_11bytes_done;
    cv_start   = ((state_q == IDLE) && value_valid) ||
                 (wait_done && (value_valid || pend_vld_q));
    cv_bin     = (wait_done && !value_valid) ? pend_val_q : v_sat;
    pend_store = value_valid && (state_q != IDLE) && !wait_done;
  end

  bin2dec_3dig u_bin2dec (
    .sclk  (sclk),
    .rst   (rst),
    .start (cv_start),
    .bin   (cv_bin),
    .busy  (cv_busy),
    .done  (cv_done),
    .h     (cv_h),
    .t     (cv_t),
    .u     (cv_u)
  );

  always_comb begin
    h_chr = dig2asc(cv_h);
    t_chr = dig2asc(cv_t);
    u_chr = dig2asc(cv_u);
`ifdef ZERO_BLANK_EN
    if (cv_h == 4'd0) begin
      h_chr = ASC_SP;
      if (cv_t == 4'd0) t_chr = ASC_SP;
    end
`endif
    frame_d = {PREFIX_COUNT, h_chr, t_chr, u_chr, ASC_CR, ASC_LF};
  end

  // The converter owns the hundreds/tens split; CONV_H here spans the whole conversion.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      msg_done_q <= 1'b0;
      ovw_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      trig_q     <= 1'b0;
      msg_done_q <= 1'b0;
      ovw_q      <= 1'b0;
      if (pend_store) begin
        pend_val_q <= v_sat;
        pend_vld_q <= 1'b1;
        ovw_q      <= pend_vld_q;
      end
      case (state_q)
        IDLE: begin
          if (value_valid) begin
            state_q <= CONV_H;
            busy_q  <= 1'b1;
          end
        end
        CONV_H: begin
          if (cv_done) begin
            state_q <= EMIT;
          end else if (!cv_busy) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        EMIT: begin
          frame_q <= frame_d;
          trig_q  <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (send_11bytes_done) begin
            msg_done_q <= 1'b1;
            if (cv_start) begin
              state_q    <= CONV_H;
              pend_vld_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign send_11bytes      = frame_q;
  assign send_11bytes_trig = trig_q;
  assign busy              = busy_q;
  assign msg_done          = msg_done_q;
  assign pend_overwrite    = ovw_q;

endmodule

// File: tb/tb_uart_count_msg_fmt.sv
// Bench for uart_count_msg_fmt: message-level reference model plus a lazy 11-byte sender model.
module tb_uart_count_msg_fmt;

  logic        sclk = 1'b0;
  logic        rst;
  logic [9:0]  value;
  logic        value_valid;
  logic [87:0] send_11bytes;
  logic        send_11bytes_trig;
  logic        send_11bytes_done;
  logic        busy;
  logic        msg_done;
  logic        pend_overwrite;

  uart_count_msg_fmt #(.VALUE_W(10), .SAT_VAL(999)) dut (
    .sclk              (sclk),
    .rst               (rst),
    .value             (value),
    .value_valid       (value_valid),
    .send_11bytes      (send_11bytes),
    .send_11bytes_trig (send_11bytes_trig),
    .send_11bytes_done (send_11bytes_done),
    .busy              (busy),
    .msg_done          (msg_done),
    .pend_overwrite    (pend_overwrite)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 converting, 2 waiting for sender done.
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_cur = 0;
  int          m_pend = 0;
  bit          m_pend_v = 0;
  logic        exp_busy = 0;
  logic        exp_trig = 0;
  logic        exp_msgd = 0;
  logic        exp_ovw = 0;
  logic [87:0] exp_frame = '0;
  byte unsigned m_msg [11];

  bit snd_active = 0;
  bit snd_finished = 0;
  bit auto_done = 1;
  int snd_idx = 0;
  int snd_gap = 0;

  function automatic int sat(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  task automatic start_conv(input int v);
    m_cur   = v;
    m_cnt   = v / 100 + (v / 10) % 10 + 3;
    m_phase = 1;
  endtask

  task automatic load_msg(input int v);
    logic [47:0] pfx;
    int hh, tt, uu;
    pfx = "COUNT:";
    hh = v / 100;
    tt = (v / 10) % 10;
    uu = v % 10;
    for (int i = 0; i < 6; i++) m_msg[i] = pfx[47-8*i -: 8];
    m_msg[6] = 8'(48 + hh);
    m_msg[7] = 8'(48 + tt);
    m_msg[8] = 8'(48 + uu);
`ifdef ZERO_BLANK_EN
    if (hh == 0) begin
      m_msg[6] = 8'h20;
      if (tt == 0) m_msg[7] = 8'h20;
    end
`endif
    m_msg[9]  = 8'h0D;
    m_msg[10] = 8'h0A;
    for (int i = 0; i < 11; i++) exp_frame[87-8*i -: 8] = m_msg[i];
  endtask

  task automatic model_edge(input bit vv, input int val, input bit dn, input bit r);
    int vs, ph;
    vs = sat(val);
    ph = m_phase;
    exp_trig = 0;
    exp_msgd = 0;
    exp_ovw  = 0;
    if (r) begin
      m_phase = 0; m_pend_v = 0; exp_busy = 0; exp_frame = '0;
      snd_active = 0; snd_finished = 0;
      return;
    end
    if (vv && ph != 0 && !(ph == 2 && dn)) begin
      exp_ovw  = m_pend_v;
      m_pend   = vs;
      m_pend_v = 1;
    end
    case (ph)
      0: if (vv) start_conv(vs);
      1: begin
        m_cnt--;
        if (m_cnt == 0) begin
          exp_trig = 1;
          m_phase  = 2;
          load_msg(m_cur);
          snd_active = 1; snd_idx = 0; snd_gap = 0; snd_finished = 0;
        end
      end
      default: begin
        if (dn) begin
          exp_msgd = 1;
          if (vv) begin
            start_conv(vs); m_pend_v = 0;
          end else if (m_pend_v) begin
            start_conv(m_pend); m_pend_v = 0;
          end else begin
            m_phase = 0;
          end
        end
      end
    endcase
    exp_busy = (m_phase != 0);
  endtask

  // One clock: sender reads a byte lazily, inputs driven, model and DUT advance, outputs checked.
  task automatic cyc(input bit vv, input int val, input bit dn_force, input bit r);
    bit dn;
    if (snd_active) begin
      if (snd_gap > 0) begin
        snd_gap--;
      end else begin
        chk("tx_byte", send_11bytes[87-8*snd_idx -: 8], m_msg[snd_idx]);
        snd_idx++;
        snd_gap = $urandom_range(0, 2);
        if (snd_idx == 11) begin
          snd_active = 0;
          snd_finished = 1;
        end
      end
    end
    dn = dn_force;
    if (auto_done && snd_finished) dn = 1;
    if (dn) snd_finished = 0;
    rst = r;
    value = 10'(val);
    value_valid = vv;
    send_11bytes_done = dn;
    @(posedge sclk);
    model_edge(vv, val, dn, r);
    @(negedge sclk);
    chk("busy", busy, exp_busy);
    chk("trig", send_11bytes_trig, exp_trig);
    chk("msg_done", msg_done, exp_msgd);
    chk("pend_overwrite", pend_overwrite, exp_ovw);
    chk("frame", send_11bytes, exp_frame);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic wait_phase(input int ph, input int maxc);
    int n;
    n = 0;
    while (m_phase != ph && n < maxc) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    if (m_phase != ph) chk("timeout_phase", 88'(m_phase), 88'(ph));
  endtask

  task automatic wait_sent(input int maxc);
    int n;
    n = 0;
    while (!snd_finished && n < maxc) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    if (!snd_finished) chk("timeout_sent", 88'(snd_finished), 88'(1));
  endtask

  initial begin
    rst = 1'b1;
    value = '0;
    value_valid = 1'b0;
    send_11bytes_done = 1'b0;

    // T1: reset, then value 0
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    auto_done = 1;
    cyc(1, 0, 0, 0);
    wait_phase(0, 200);
    idle(2);

    // T2/T3: extremes, saturation, interior zero
    cyc(1, 999, 0, 0);
    wait_phase(0, 200);
    cyc(1, 1023, 0, 0);
    wait_phase(0, 200);
    cyc(1, 105, 0, 0);
    wait_phase(0, 200);
    cyc(1, 50, 0, 0);
    wait_phase(0, 200);

    // T4: two strobes while waiting; the newer one replaces the older
    auto_done = 0;
    cyc(1, 12, 0, 0);
    wait_phase(2, 50);
    cyc(1, 34, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 56, 0, 0);
    wait_sent(100);
    cyc(0, 0, 1, 0);
    auto_done = 1;
    wait_phase(0, 200);

    // T5: strobe coincident with done, older value pending
    auto_done = 0;
    cyc(1, 20, 0, 0);
    wait_phase(2, 50);
    cyc(1, 40, 0, 0);
    wait_sent(100);
    cyc(1, 77, 1, 0);
    auto_done = 1;
    wait_phase(0, 200);
    idle(3);

    // T6: reset during tens conversion, then during WAIT; stray dones after each
    cyc(1, 999, 0, 0);
    idle(12);
    cyc(0, 0, 0, 1);
    idle(25);
    cyc(0, 0, 1, 0);
    idle(2);
    auto_done = 0;
    cyc(1, 5, 0, 0);
    wait_phase(2, 50);
    cyc(1, 8, 0, 0);
    cyc(0, 0, 0, 1);
    idle(5);
    cyc(0, 0, 1, 0);
    idle(3);
    auto_done = 1;

    // Randomized traffic with boundary-biased values, stray dones and rare resets
    for (int k = 0; k < 3000; k++) begin
      int pick;
      int val;
      bit vv;
      bit dn;
      bit r;
      vv = ($urandom_range(0, 5) == 0);
      pick = int'($urandom_range(0, 9));
      case (pick)
        0: val = 0;
        1: val = 9;
        2: val = 10;
        3: val = 99;
        4: val = 100;
        5: val = 999;
        6: val = 1000;
        7: val = 1023;
        default: val = int'($urandom_range(0, 1023));
      endcase
      dn = (m_phase != 2) && ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 399) == 0);
      cyc(vv, val, dn, r);
    end
    wait_phase(0, 400);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
